// File: rtl/openhw_div_ctrl_pkg.sv
// Shared types and helpers for the MDU iterative divider controller.
package openhw_div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Number of datapath steps for one divide; W forms only shorten on RV64.
  function automatic int stepCount(input int xlen, input int divbits, input logic w64);
    if ((xlen == 64) && w64) return 32 / divbits;
    return xlen / divbits;
  endfunction

  // Counter width able to hold the full step count.
  function automatic int cntWidth(input int xlen, input int divbits);
    return $clog2(xlen / divbits + 1);
  endfunction

endpackage

// File: rtl/openhw_div_cnt.sv
// Loadable down-counter tracking remaining divider steps.
module openhw_div_cnt #(
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          dec,
  input  logic          clear,
  input  logic [CW-1:0] loadVal,
  output logic [CW-1:0] count,
  output logic          lastStep
);

  // Clear wins over load, load wins over decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      count <= '0;
    else if (clear) count <= '0;
    else if (load)  count <= loadVal;
    else if (dec)   count <= count - CW'(1);
  end

  // The step performed while count is one is the final one.
  assign lastStep = (count == CW'(1));

endmodule

// File: rtl/openhw_div_ctrl.sv
// Sequencing controller for the iterative integer divider in the MDU.
module openhw_div_ctrl
  import openhw_div_ctrl_pkg::*;
#(
  parameter  int XLEN    = 64,
  parameter  int DIVBITS = 1,
  localparam int CW      = cntWidth(XLEN, DIVBITS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          IntDivE,
  input  logic          W64E,
  input  logic          DivByZeroE,
  input  logic          FlushE,
  input  logic          StallM,
  output logic          DivLoadE,
  output logic          DivStepE,
  output logic          DivDoneE,
  output logic          DivBusyE,
  output logic [CW-1:0] DivCountE
);

  div_state_t    state;
  logic          start;
  logic          lastStep;
  logic          cntLoad;
  logic          cntDec;
  logic [CW-1:0] cntLoadVal;

  // Reset also masks start so every output is low while reset is held.
  assign start      = (state == IDLE) & IntDivE & ~FlushE & ~reset;
  assign cntLoad    = start & ~DivByZeroE;
  assign cntDec     = (state == BUSY) & ~FlushE;
  assign cntLoadVal = CW'(stepCount(XLEN, DIVBITS, W64E));

  openhw_div_cnt #(.CW(CW)) cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cntLoad),
    .dec      (cntDec),
    .clear    (FlushE),
    .loadVal  (cntLoadVal),
    .count    (DivCountE),
    .lastStep (lastStep)
  );

  // State sequencing; flush overrides both step completion and StallM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) state <= DivByZeroE ? DONE : BUSY;
        BUSY: begin
          if (FlushE)        state <= IDLE;
          else if (lastStep) state <= DONE;
        end
        DONE: if (FlushE | ~StallM) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign DivLoadE = start;
  assign DivStepE = (state == BUSY);
  assign DivDoneE = (state == DONE);
  assign DivBusyE = start | (state == BUSY);

endmodule

// File: tb/tb_openhw_div_ctrl.sv
// Self-checking bench for openhw_div_ctrl (main instance XLEN=64/DIVBITS=1, second DIVBITS=4).
module tb_openhw_div_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, intDiv, w64, dbz, flush, stall;
  logic intDiv4, w64b;
  logic load, step, done, busy;
  logic [6:0] cnt;
  logic load4, step4, done4, busy4;
  logic [4:0] cnt4;

  openhw_div_ctrl #(.XLEN(64), .DIVBITS(1)) dut (
    .clk(clk), .reset(reset), .IntDivE(intDiv), .W64E(w64), .DivByZeroE(dbz),
    .FlushE(flush), .StallM(stall), .DivLoadE(load), .DivStepE(step),
    .DivDoneE(done), .DivBusyE(busy), .DivCountE(cnt)
  );

  openhw_div_ctrl #(.XLEN(64), .DIVBITS(4)) u4 (
    .clk(clk), .reset(reset), .IntDivE(intDiv4), .W64E(w64b), .DivByZeroE(dbz),
    .FlushE(flush), .StallM(stall), .DivLoadE(load4), .DivStepE(step4),
    .DivDoneE(done4), .DivBusyE(busy4), .DivCountE(cnt4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {load, step, done, busy};
  endfunction

  typedef struct {
    logic iDiv, w, z, f, s;
    logic [3:0] expFlags;   // {load, step, done, busy}
    int expCnt;
  } vec_t;

  vec_t tbl[10];

  // Run one op on the chosen instance and measure load/step/busy counts and count sequence.
  task automatic measure(input bit which, input bit w, input int expN, input string tag);
    int busyN, stepN, loadN, badCnt, c;
    bit gotDone;
    logic bL, bS, bD, bB;
    int bC;
    busyN = 0; stepN = 0; loadN = 0; badCnt = 0; gotDone = 0; c = 0;
    @(negedge clk);
    if (which) begin intDiv4 = 1; w64b = w; end
    else begin intDiv = 1; w64 = w; end
    dbz = 0; flush = 0; stall = 0;
    while (!gotDone && c < 200) begin
      #1;
      bL = which ? load4 : load;  bS = which ? step4 : step;
      bD = which ? done4 : done;  bB = which ? busy4 : busy;
      bC = which ? int'(cnt4) : int'(cnt);
      if (bD) begin
        gotDone = 1;
        intDiv = 0; intDiv4 = 0;
        if (bB || bS || bL) badCnt++;
      end else begin
        if (bB) busyN++;
        if (bL) loadN++;
        if (bS) begin
          stepN++;
          if (bC != expN - stepN + 1) badCnt++;
        end
        c++;
        @(negedge clk);
      end
    end
    chk({tag, "_done"}, gotDone, 1);
    chk({tag, "_load_cycles"}, loadN, 1);
    chk({tag, "_step_cycles"}, stepN, expN);
    chk({tag, "_busy_cycles"}, busyN, expN + 1);
    chk({tag, "_count_seq_errs"}, badCnt, 0);
    @(negedge clk);
  endtask

  int n, doneN, badL, seen, mLeft, mN;
  bit mDone, mStart;

  initial begin
    reset = 1; intDiv = 0; w64 = 0; dbz = 0; flush = 0; stall = 0;
    intDiv4 = 0; w64b = 0;

    // reset state, including with a request pending during reset
    repeat (2) @(negedge clk);
    #1 chk("reset_flags", flags(), 4'b0000);
    chk("reset_count", cnt, 0);
    intDiv = 1;
    #1 chk("reset_masks_load", flags(), 4'b0000);
    @(negedge clk);
    intDiv = 0; reset = 0;
    #1 chk("post_reset_idle", flags(), 4'b0000);

    // table: div-by-zero with stall, W op flushed, flush suppressing start
    tbl[0] = '{1,0,1,0,0, 4'b1001, 0};
    tbl[1] = '{1,0,0,0,1, 4'b0010, 0};
    tbl[2] = '{1,0,0,0,1, 4'b0010, 0};
    tbl[3] = '{1,0,0,0,0, 4'b0010, 0};
    tbl[4] = '{1,1,0,0,0, 4'b1001, 0};
    tbl[5] = '{1,0,0,0,0, 4'b0101, 32};
    tbl[6] = '{1,0,0,1,0, 4'b0101, 31};
    tbl[7] = '{0,0,0,0,0, 4'b0000, 0};
    tbl[8] = '{1,0,0,1,0, 4'b0000, 0};
    tbl[9] = '{0,0,0,0,0, 4'b0000, 0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      intDiv = tbl[i].iDiv; w64 = tbl[i].w; dbz = tbl[i].z;
      flush = tbl[i].f; stall = tbl[i].s;
      #1;
      chk($sformatf("vec%0d_flags", i), flags(), tbl[i].expFlags);
      chk($sformatf("vec%0d_count", i), cnt, tbl[i].expCnt);
    end
    @(negedge clk);
    intDiv = 0; dbz = 0; flush = 0; stall = 0;

    // full-length and W-length operations on both instances
    measure(0, 0, 64, "x64");
    measure(0, 1, 32, "x64w");
    measure(1, 0, 16, "db4");
    measure(1, 1, 8, "db4w");

    // StallM holds DONE; no restart while IntDivE stays high
    @(negedge clk);
    intDiv = 1; w64 = 1; dbz = 0; stall = 1;
    n = 0;
    #1;
    while (!done && n < 100) begin @(negedge clk); #1; n++; end
    chk("stall_done_reached", done, 1);
    doneN = 1; badL = int'(load);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      doneN += int'(done); badL += int'(load);
    end
    @(negedge clk);
    stall = 0;
    #1 doneN += int'(done); badL += int'(load);
    chk("stall_done_cycles", doneN, 6);
    chk("stall_no_reload", badL, 0);
    @(negedge clk);
    w64 = 0;
    #1 chk("b2b_restart_flags", flags(), 4'b1001);

    // flush at step 20 of 64 aborts without DONE
    for (int s = 1; s <= 20; s++) begin @(negedge clk); #1; end
    chk("flush_step20_count", cnt, 45);
    flush = 1;
    @(negedge clk);
    flush = 0; intDiv = 0;
    #1 chk("flush_idle_flags", flags(), 4'b0000);
    chk("flush_count_cleared", cnt, 0);
    seen = 0;
    for (int k = 0; k < 70; k++) begin @(negedge clk); #1; seen += int'(done); end
    chk("flush_no_done", seen, 0);
    measure(0, 0, 64, "after_flush");

    // asynchronous reset mid-BUSY at count 40
    @(negedge clk);
    intDiv = 1; w64 = 0;
    for (int s = 1; s <= 25; s++) begin @(negedge clk); #1; end
    chk("pre_reset_count", cnt, 40);
    #2 reset = 1;
    #1 chk("async_reset_flags", flags(), 4'b0000);
    chk("async_reset_count", cnt, 0);
    @(negedge clk);
    intDiv = 0; reset = 0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      #1 seen += int'(flags() != 4'b0000) + int'(cnt != 0);
      @(negedge clk);
    end
    chk("stays_idle_after_reset", seen, 0);

    // randomized traffic against a transaction-level model
    mLeft = 0; mDone = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      intDiv = ($urandom % 8) != 0;
      w64    = $urandom % 2;
      dbz    = ($urandom % 8) == 0;
      flush  = ($urandom % 40) == 0;
      stall  = $urandom % 2;
      #1;
      mStart = (mLeft == 0) && !mDone && intDiv && !flush;
      chk($sformatf("rand%0d_flags", cyc), flags(),
          {mStart, mLeft > 0, mDone, mStart || (mLeft > 0)});
      chk($sformatf("rand%0d_count", cyc), cnt, mLeft);
      mN = w64 ? 32 : 64;
      if (flush) begin
        mLeft = 0; mDone = 0;
      end else if (mStart) begin
        if (dbz) mDone = 1;
        else mLeft = mN;
      end else if (mLeft > 0) begin
        mLeft--;
        if (mLeft == 0) mDone = 1;
      end else if (mDone && !stall) begin
        mDone = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/openhw_div_ctrl.md
Name: openhw_div_ctrl

Overview:
- Sequencing controller for the iterative integer divider inside the MDU.
- Accepts div/rem instructions from the Execute stage and issues load and step enables to the divider datapath.
- Counts iterations, drives DivBusyE to stall the pipeline, and holds the finished result until the Memory-stage register can accept it.
- Handles divide-by-zero early termination, W-type shortened iteration, and flush abort.

Parameters:
- XLEN, 64, integer datapath width (32 or 64).
- DIVBITS, 1, quotient bits retired per step; power of 2, must divide 32.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- IntDivE  in  1  valid div/divu/rem/remu (incl. W forms) in Execute
- W64E  in  1  W-type op; honoured only when XLEN=64
- DivByZeroE  in  1  divisor (after W truncation) equals zero
- FlushE  in  1  Execute-stage flush
- StallM  in  1  Memory-stage stall
- DivLoadE  out  1  datapath loads operands and pre-processes sign
- DivStepE  out  1  datapath performs one DIVBITS iteration
- DivDoneE  out  1  datapath result is valid this cycle
- DivBusyE  out  1  stall request to hazard unit
- DivCountE  out  CW  remaining steps; CW = clog2(XLEN/DIVBITS + 1)

Behaviour:
- Step count N:
  - XLEN/DIVBITS when XLEN=32 or W64E=0.
  - 32/DIVBITS when XLEN=64 and W64E=1.
  - Example: XLEN=64, DIVBITS=1 gives N=64, or 32 for W.
- States: IDLE, BUSY, DONE.
- Reset (asynchronous, active-high), including mid-operation:
  - state becomes IDLE; DivCountE becomes 0.
  - All outputs 0 in the cycle after reset deasserts, unless a start is requested.
- Start condition: Start = state==IDLE & IntDivE & ~FlushE.
- IDLE:
  - DivLoadE = Start.
  - On Start with DivByZeroE=1: go to DONE. No steps are taken; the datapath forms quotient all-ones and remainder = dividend.
  - On Start with DivByZeroE=0: go to BUSY and load DivCountE = N.
- BUSY:
  - DivStepE=1 every cycle; DivCountE decrements by 1 per cycle.
  - When DivCountE==1 (last step), go to DONE next cycle.
  - StallM is ignored in BUSY.
- DONE:
  - DivDoneE=1; DivCountE=0.
  - If ~StallM: go to IDLE (result captured into M and the instruction advances).
  - If StallM: hold DONE with the result stable. No restart, although IntDivE stays high.
- DivBusyE = Start | state==BUSY. DivBusyE is 0 in DONE so the instruction can leave Execute.
- Latency (non-zero divisor): DivBusyE high for N+1 consecutive cycles (one load cycle plus N steps); DONE is entered on the following cycle.
- Latency (divide by zero): DivBusyE high for exactly 1 cycle.
- FlushE:
  - In IDLE: suppresses Start.
  - In BUSY or DONE: go to IDLE next edge, no DivDoneE afterwards, counter cleared.
  - FlushE takes priority over step completion and over StallM.
- Simultaneous exit and new request: DONE exit and a new IntDivE in the same cycle do not start the new op. It starts from IDLE on the next cycle, so back-to-back divides are separated by 1 cycle.
- Output encoding: DivLoadE, DivStepE and DivDoneE are mutually exclusive (one-hot or zero).
- W64E: sampled only at Start; ignored afterwards.

Decomposition:
- Shared cvw package:
  - div_state_t enum {IDLE, BUSY, DONE}.
  - Function for N(XLEN, DIVBITS, W64) and the CW width constant.
- One sub-module: openhw_div_cnt, a loadable down-counter with load, decrement and clear, plus a last-step flag (count==1).

Test Plan:
1. XLEN=64, DIVBITS=1, IntDivE=1, W64E=0, DivByZeroE=0 held -> DivLoadE 1 cycle, DivStepE 64 cycles, DivBusyE 65 cycles, then DivDoneE=1; DivCountE sequence 64..1 during BUSY.
2. Same with W64E=1 -> 32 steps, DivBusyE 33 cycles; with DIVBITS=4 -> 16 steps, DivBusyE 17 cycles.
3. DivByZeroE=1 at Start -> DivBusyE 1 cycle, DivStepE never asserted, DivDoneE next cycle.
4. StallM=1 for 5 cycles entering DONE -> DivDoneE held 6 cycles, no second DivLoadE while IntDivE stays 1; IDLE after StallM drops.
5. FlushE pulse at step 20 of 64 -> IDLE next cycle, DivBusyE=0, DivCountE=0, no DivDoneE; new IntDivE then restarts with a full 64 steps.
6. reset asserted asynchronously mid-BUSY (count 40) -> outputs and count 0 immediately; after release with IntDivE=0 the block stays IDLE.
